// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined carry-lookahead adder/subtractor. The operands are split into
// GROUP-bit lookahead groups. The group carry chain is spread over STAGES
// register stages, with valid/ready handshakes on the input and output sides.
//
// Result:   a + (sub ? ~b : b) + (sub ? ~cin : cin)  mod 2^WIDTH
// Latency:  exactly STAGES cycles from the input transfer to out_valid.
// The final stage register is also the output register.
//
// Parameters
//   WIDTH   operand/result width (a multiple of GROUP)
//   GROUP   bits per lookahead group
//   STAGES  register stages, 1..WIDTH/GROUP
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (combinational from out_ready)
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   sat        (only with CLA_SATURATE_EN) clamp the result on signed overflow
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result bits
//   cout       carry-out (add) / NOT borrow-out (sub)
//   ovf        two's-complement signed overflow
//
// Configuration macro: CLA_SATURATE_EN adds the `sat` input. Without the
// macro the result always wraps.
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG   = WIDTH / GROUP;
  localparam int LAST = STAGES - 1;

  // One lookahead group. Every internal carry is formed directly from the
  // group's generate/propagate terms and the group carry-in, rather than
  // rippling through the group. Returns {carry_out, sum_bits}.
  function automatic logic [GROUP:0] cla_group(
    input logic [GROUP-1:0] ga,
    input logic [GROUP-1:0] gb,
    input logic             gc
  );
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             run_p;
    g    = ga & gb;
    p    = ga ^ gb;
    c    = {(GROUP+1){1'b0}};
    c[0] = gc;
    for (int j = 1; j <= GROUP; j++) begin
      run_p = 1'b1;
      for (int k = j - 1; k >= 0; k--) begin
        c[j]  = c[j] | (run_p & g[k]);
        run_p = run_p & p[k];
      end
      c[j] = c[j] | (run_p & gc);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  logic             adv_s;
  logic [WIDTH-1:0] bb_s;
  logic             c0_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;

  // The whole pipe advances together. Bubbles are kept, so the pipe never collapses.
  assign adv_s     = ~out_valid_r | out_ready;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  // Operand preparation. The inverted b and the inverted cin carry the
  // subtract decision down the pipe, so sub itself is not needed later.
  always_comb begin
    bb_s = b;
    c0_s = cin;
    if (sub) begin
      bb_s = ~b;
      c0_s = ~cin;
    end else begin
      bb_s = b;
      c0_s = cin;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO = s * NG / STAGES;
    localparam int HI = (s == LAST) ? NG : (s + 1) * NG / STAGES;

    logic [WIDTH-1:0] in_a_s;
    logic [WIDTH-1:0] in_b_s;
    logic [WIDTH-1:0] in_sum_s;
    logic             in_c_s;
    logic             in_v_s;
`ifdef CLA_SATURATE_EN
    logic             in_sat_s;
`endif
    logic [WIDTH-1:0] nxt_sum_s;
    logic             nxt_c_s;
    logic             c_v;
    logic [GROUP:0]   grp_v;

    if (s == 0) begin : g_src
      assign in_a_s   = a;
      assign in_b_s   = bb_s;
      assign in_sum_s = {WIDTH{1'b0}};
      assign in_c_s   = c0_s;
      assign in_v_s   = in_valid;
`ifdef CLA_SATURATE_EN
      assign in_sat_s = sat;
`endif
    end else begin : g_src
      assign in_a_s   = g_stage[s-1].g_reg.a_r;
      assign in_b_s   = g_stage[s-1].g_reg.b_r;
      assign in_sum_s = g_stage[s-1].g_reg.sum_r;
      assign in_c_s   = g_stage[s-1].g_reg.c_r;
      assign in_v_s   = g_stage[s-1].g_reg.v_r;
`ifdef CLA_SATURATE_EN
      assign in_sat_s = g_stage[s-1].g_reg.sat_r;
`endif
    end

    // Resolve this stage's groups, starting from the carry registered by the previous stage.
    always_comb begin
      nxt_sum_s = in_sum_s;
      c_v       = in_c_s;
      grp_v     = {(GROUP+1){1'b0}};
      for (int gi = LO; gi < HI; gi++) begin
        grp_v = cla_group(in_a_s[gi*GROUP +: GROUP], in_b_s[gi*GROUP +: GROUP], c_v);
        nxt_sum_s[gi*GROUP +: GROUP] = grp_v[GROUP-1:0];
        c_v = grp_v[GROUP];
      end
      nxt_c_s = c_v;
    end

    if (s < LAST) begin : g_reg
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] sum_r;
      logic             c_r;
      logic             v_r;
`ifdef CLA_SATURATE_EN
      logic             sat_r;
`endif
      // Intermediate stage register. It holds the resolved sum bits, the
      // group carry, and the operand bits still to be resolved.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r   <= {WIDTH{1'b0}};
          b_r   <= {WIDTH{1'b0}};
          sum_r <= {WIDTH{1'b0}};
          c_r   <= 1'b0;
          v_r   <= 1'b0;
`ifdef CLA_SATURATE_EN
          sat_r <= 1'b0;
`endif
        end else if (adv_s) begin
          a_r   <= in_a_s;
          b_r   <= in_b_s;
          sum_r <= nxt_sum_s;
          c_r   <= nxt_c_s;
          v_r   <= in_v_s;
`ifdef CLA_SATURATE_EN
          sat_r <= in_sat_s;
`endif
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] res_s;
      logic             ovf_s;

      // The MSB carry-in is recovered as a^bb^sum at the MSB. Overflow is
      // that carry-in XOR the final carry-out.
      always_comb begin
        ovf_s = in_a_s[WIDTH-1] ^ in_b_s[WIDTH-1] ^ nxt_sum_s[WIDTH-1] ^ nxt_c_s;
        res_s = nxt_sum_s;
`ifdef CLA_SATURATE_EN
        // On overflow both operands share a's sign, and a's sign is the sign the true result should have.
        if (in_sat_s && ovf_s) begin
          if (in_a_s[WIDTH-1]) begin
            res_s = {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            res_s = {1'b0, {(WIDTH-1){1'b1}}};
          end
        end else begin
          res_s = nxt_sum_s;
        end
`endif
      end

      // Output register (the last pipeline stage). It holds its value while stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_r <= 1'b0;
          sum_r       <= {WIDTH{1'b0}};
          cout_r      <= 1'b0;
          ovf_r       <= 1'b0;
        end else if (adv_s) begin
          out_valid_r <= in_v_s;
          sum_r       <= res_s;
          cout_r      <= nxt_c_s;
          ovf_r       <= ovf_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance: WIDTH=16, GROUP=4, STAGES=2
  logic        v16 = 1'b0, rdy16, ov16, ordy16 = 1'b1, cin16 = 1'b0, sub16 = 1'b0, co16, of16;
  logic [15:0] a16 = 16'h0, b16 = 16'h0, s16;
`ifdef CLA_SATURATE_EN
  logic        sat16 = 1'b0;
`endif

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16),
`ifdef CLA_SATURATE_EN
    .sat(sat16),
`endif
    .out_valid(ov16), .out_ready(ordy16), .sum(s16), .cout(co16), .ovf(of16));

  // Exhaustive instance: WIDTH=4, GROUP=4, STAGES=1
  logic       v4 = 1'b0, rdy4, ov4, cin4 = 1'b0, sub4 = 1'b0, co4, of4;
  logic [3:0] a4 = 4'h0, b4 = 4'h0, s4;
  logic       ordy4 = 1'b1;
`ifdef CLA_SATURATE_EN
  logic       sat4 = 1'b0;
`endif

  cla_pipe_adder #(.WIDTH(4), .GROUP(4), .STAGES(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4),
`ifdef CLA_SATURATE_EN
    .sat(sat4),
`endif
    .out_valid(ov4), .out_ready(ordy4), .sum(s4), .cout(co4), .ovf(of4));

  // Sweep instance: WIDTH=8, GROUP=2, STAGES=4
  logic       v8 = 1'b0, rdy8, ov8, cin8 = 1'b0, sub8 = 1'b0, co8, of8;
  logic [7:0] a8 = 8'h0, b8 = 8'h0, s8;
  logic       ordy8 = 1'b1;
`ifdef CLA_SATURATE_EN
  logic       sat8 = 1'b0;
`endif

  cla_pipe_adder #(.WIDTH(8), .GROUP(2), .STAGES(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8),
`ifdef CLA_SATURATE_EN
    .sat(sat8),
`endif
    .out_valid(ov8), .out_ready(ordy8), .sum(s8), .cout(co8), .ovf(of8));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t tbl[14];
  int   exp_st[14];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference in integer arithmetic. Returns {ovf, cout, sum}.
  function automatic int ref_calc(input int w, input int a, input int b, input int cin, input int sub);
    int mask, half, u, sa, sb, sr, co, ov;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    u    = (sub != 0) ? (a - b - cin) : (a + b + cin);
    co   = (sub != 0) ? ((u >= 0) ? 1 : 0) : ((u > mask) ? 1 : 0);
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    sr   = (sub != 0) ? (sa - sb - cin) : (sa + sb + cin);
    ov   = ((sr >= half) || (sr < -half)) ? 1 : 0;
    return (ov << (w + 1)) | (co << w) | (u & mask);
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, snd, rcv, stale, snd4, rcv4, snd8, rcv8;
    logic tk, tk4, tk8;

    tbl[0]  = '{16'h0003, 16'h0005, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0};
    tbl[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[7]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[10] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[12] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[13] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst    = 1'b0;
    ordy16 = 1'b0;
    #1;
    chk("reset_out_valid", ov16, 0);
    chk("reset_sum", s16, 0);
    chk("reset_cout", co16, 0);
    chk("reset_ovf", of16, 0);
    chk("reset_in_ready", rdy16, 1);
    chk("reset_out_valid_w4", ov4, 0);
    chk("reset_out_valid_w8", ov8, 0);
    ordy16 = 1'b1;

    // Directed table: one beat at a time, checking latency and result
    for (int i = 0; i < 14; i++) begin
      a16 = tbl[i].a; b16 = tbl[i].b; cin16 = tbl[i].cin; sub16 = tbl[i].sub;
      v16 = 1'b1;
      #1;
      chk("vec_in_ready", rdy16, 1);
      tick();
      v16 = 1'b0;
      n = 1;
      while (!ov16 && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("vec%0d_latency", i), n, 2);
      chk($sformatf("vec%0d_sum", i), s16, tbl[i].s);
      chk($sformatf("vec%0d_cout", i), co16, tbl[i].c);
      chk($sformatf("vec%0d_ovf", i), of16, tbl[i].o);
      tick();
    end

`ifdef CLA_SATURATE_EN
    // Saturation: positive and negative clamps
    a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; sat16 = 1'b1; v16 = 1'b1;
    tick();
    a16 = 16'h8000; b16 = 16'h8000;
    tick();
    v16 = 1'b0;
    chk("sat_pos_sum", s16, 16'h7FFF);
    chk("sat_pos_ovf", of16, 1);
    chk("sat_pos_cout", co16, 0);
    tick();
    chk("sat_neg_sum", s16, 16'h8000);
    chk("sat_neg_cout", co16, 1);
    tick();
    sat16 = 1'b0;
`endif

    // Stream of 14 beats; out_ready drops for 3 cycles in the middle
    for (int k = 0; k < 14; k++)
      exp_st[k] = ref_calc(16, 16'h1000 + 16'h0123 * k, 16'h0F0F ^ k, (k >> 1) & 1, k & 1);
    snd = 0; rcv = 0;
    for (int cyc = 0; cyc < 60 && rcv < 14; cyc++) begin
      ordy16 = (cyc >= 12 && cyc <= 14) ? 1'b0 : 1'b1;
      if (snd < 14) begin
        v16 = 1'b1;
        a16 = 16'(16'h1000 + 16'h0123 * snd);
        b16 = 16'(16'h0F0F ^ snd);
        cin16 = 1'((snd >> 1) & 1);
        sub16 = 1'(snd & 1);
      end else begin
        v16 = 1'b0;
      end
      #1;
      if (!ordy16) begin
        chk("stall_in_ready", rdy16, 0);
        chk("stall_out_valid", ov16, 1);
        chk("stall_hold", {of16, co16, s16}, exp_st[rcv]);
      end else if (ov16) begin
        chk($sformatf("stream%0d_data", rcv), {of16, co16, s16}, exp_st[rcv]);
        if (rcv < 8) chk($sformatf("stream%0d_cycle", rcv), cyc, rcv + 2);
        rcv++;
      end
      tk = v16 & rdy16;
      @(posedge clk);
      #1;
      if (tk) snd++;
    end
    chk("stream_count", rcv, 14);
    v16 = 1'b0; ordy16 = 1'b1;
    stale = 0;
    repeat (5) begin
      tick();
      if (ov16) stale++;
    end
    chk("stream_no_dup", stale, 0);

    // Reset with two beats in flight, plus a beat presented during reset
    ordy16 = 1'b0;
    a16 = 16'h0011; b16 = 16'h0022; cin16 = 1'b0; sub16 = 1'b0; v16 = 1'b1;
    tick();
    a16 = 16'h0033;
    tick();
    chk("inflight_valid", ov16, 1);
    rst = 1'b1; a16 = 16'h0044;
    tick();
    rst = 1'b0; v16 = 1'b0; ordy16 = 1'b1;
    chk("midrst_out_valid", ov16, 0);
    stale = 0;
    repeat (6) begin
      tick();
      if (ov16) stale++;
    end
    chk("midrst_no_stale", stale, 0);

    // Exhaustive WIDTH=4, plus a full-a sweep for WIDTH=8 (b in steps of 17), streamed
    snd4 = 0; rcv4 = 0; snd8 = 0; rcv8 = 0;
    for (int cyc = 0; cyc < 16400; cyc++) begin
      v4 = (snd4 < 1024);
      a4 = 4'(snd4 & 15); b4 = 4'((snd4 >> 4) & 15);
      cin4 = 1'((snd4 >> 8) & 1); sub4 = 1'((snd4 >> 9) & 1);
      v8 = (snd8 < 16384);
      a8 = 8'(snd8 & 255); b8 = 8'(((snd8 >> 8) & 15) * 17);
      cin8 = 1'((snd8 >> 12) & 1); sub8 = 1'((snd8 >> 13) & 1);
      #1;
      if (ov4) begin
        if (rcv4 < 1024)
          chk("exh_w4", {of4, co4, s4},
              ref_calc(4, rcv4 & 15, (rcv4 >> 4) & 15, (rcv4 >> 8) & 1, (rcv4 >> 9) & 1));
        else
          chk("exh_w4_extra_beat", rcv4, 1023);
        rcv4++;
      end
      if (ov8) begin
        if (rcv8 < 16384)
          chk("exh_w8", {of8, co8, s8},
              ref_calc(8, rcv8 & 255, ((rcv8 >> 8) & 15) * 17, (rcv8 >> 12) & 1, (rcv8 >> 13) & 1));
        else
          chk("exh_w8_extra_beat", rcv8, 16383);
        rcv8++;
      end
      tk4 = v4 & rdy4;
      tk8 = v8 & rdy8;
      @(posedge clk);
      #1;
      if (tk4) snd4++;
      if (tk8) snd8++;
    end
    chk("exh_w4_count", rcv4, 1024);
    chk("exh_w8_count", rcv8, 16384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
